// File: rtl/popcount_pkg.sv
// Shared types and helpers for the streaming population counter.
// clog2 sizes the per-word count; sat_add clamps a sum to a destination width.
package popcount_pkg;

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_e;

    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Sum of two values clamped to 2^width-1; width must be 1..31.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          width);
        logic [32:0] sum;
        logic [32:0] limit;
        sum   = {1'b0, a} + {1'b0, b};
        limit = (33'd1 << width) - 33'd1;
        if (sum > limit) begin
            return limit[31:0];
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/popcount_word.sv
// Combinational ones-count of a single WIDTH-bit word.
module popcount_word
    import popcount_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] count_o
);

    // Adder chain over the word bits.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CNT_W'(data_i[i]);
        end
    end

endmodule

// File: rtl/popcount_accum.sv
// Frame-based ones accumulator: sums per-word pop counts until in_last,
// then holds the saturated total, word count and clamp flag until taken.
module popcount_accum
    import popcount_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ACC_W  = 16,
    parameter int WCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_count,
    output logic [WCNT_W-1:0] out_words,
    output logic              out_sat
);

    localparam int          POP_W   = clog2(WIDTH + 1);
    localparam logic [31:0] ACC_MAX = (32'd1 << ACC_W) - 32'd1;

    if (ACC_W < POP_W || ACC_W > 31) begin : g_acc_w_check
        $error("popcount_accum: ACC_W must be in clog2(WIDTH+1)..31");
    end

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [WCNT_W-1:0]   words_q, words_d;
    logic                sat_q, sat_d;
    logic                out_valid_q, out_valid_d;
    logic [ACC_W-1:0]    out_count_q, out_count_d;
    logic [WCNT_W-1:0]   out_words_q, out_words_d;
    logic                out_sat_q, out_sat_d;

    logic [POP_W-1:0]    pop_s;
    logic                in_ready_s;
    logic                accept_s;
    logic [ACC_W-1:0]    acc_sum_s;
    logic                overflow_s;
    logic [WCNT_W-1:0]   words_inc_s;

    popcount_word #(.WIDTH(WIDTH)) u_word (
        .data_i  (in_data),
        .count_o (pop_s)
    );

    // Saturating sums for the word being offered this cycle.
    always_comb begin
        accept_s    = in_valid && in_ready_s;
        acc_sum_s   = ACC_W'(sat_add(32'(acc_q), 32'(pop_s), ACC_W));
        overflow_s  = (32'(acc_q) + 32'(pop_s)) > ACC_MAX;
        words_inc_s = (&words_q) ? words_q : words_q + WCNT_W'(1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC: begin
                if (accept_s && in_last) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // FSM output: upstream handshake.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_ACC:  in_ready_s = !flush;
            ST_OUT:  in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Accumulator and result next-state; a flush only matters while accumulating.
    always_comb begin
        acc_d       = acc_q;
        words_d     = words_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_words_d = out_words_q;
        out_sat_d   = out_sat_q;
        if (state_q == ST_ACC) begin
            if (flush) begin
                acc_d   = '0;
                words_d = '0;
                sat_d   = 1'b0;
            end else if (accept_s && in_last) begin
                out_count_d = acc_sum_s;
                out_words_d = words_inc_s;
                out_sat_d   = sat_q | overflow_s;
                out_valid_d = 1'b1;
                acc_d       = '0;
                words_d     = '0;
                sat_d       = 1'b0;
            end else if (accept_s) begin
                acc_d   = acc_sum_s;
                words_d = words_inc_s;
                sat_d   = sat_q | overflow_s;
            end else begin
                acc_d = acc_q;
            end
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            words_q     <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_words_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            words_q     <= words_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_words_q <= out_words_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_words = out_words_q;
    assign out_sat   = out_sat_q;

endmodule
